// File: rtl/ce_pll_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
// Holds the lock FSM encoding, config validity check and 50 MHz board defaults.
package ce_pll_pkg;

   typedef enum logic {
      RELOCK = 1'b0,
      LOCKED = 1'b1
   } lock_state_e;

   // Standard 50 MHz board set: ch0..ch4 = 9/25, 6/25, 3/25, 12/25, 24/25 (ch0 in LSBs)
   localparam int unsigned STD_NUM_CH = 5;
   localparam int unsigned STD_ACC_W  = 16;
   localparam logic [STD_NUM_CH*STD_ACC_W-1:0] STD_DEF_NUM =
      {16'd24, 16'd12, 16'd3, 16'd6, 16'd9};
   localparam logic [STD_NUM_CH*STD_ACC_W-1:0] STD_DEF_DEN =
      {16'd25, 16'd25, 16'd25, 16'd25, 16'd25};

   // Arguments are zero-extended to 32 bits by the caller (ACC_W <= 32).
   function automatic logic cfg_is_valid(input logic [31:0] num,
                                         input logic [31:0] den,
                                         input logic [31:0] ch,
                                         input int unsigned num_ch);
      return (den != '0) && (num != '0) && (num <= den) && (ch < num_ch);
   endfunction

endpackage

// File: rtl/ce_frac_acc.sv
// One channel's fractional accumulator: strobe rate averages num/den per clk.
// Strobe is registered; clr zeroes the phase and drops the strobe on that edge.
module ce_frac_acc #(
   parameter int unsigned ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [ACC_W-1:0] num,
   input  logic [ACC_W-1:0] den,
   output logic             strobe
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic             strobe_q, strobe_d;
   logic [ACC_W:0]   sum;
   logic [ACC_W:0]   diff;

   // acc < den and num <= den keep sum below 2*den, so one subtract suffices
   always_comb begin
      sum      = {1'b0, acc_q} + {1'b0, num};
      diff     = sum - {1'b0, den};
      acc_d    = sum[ACC_W-1:0];
      strobe_d = 1'b0;
      if (sum >= {1'b0, den}) begin
         acc_d    = diff[ACC_W-1:0];
         strobe_d = 1'b1;
      end
      if (clr) begin
         acc_d    = '0;
         strobe_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q    <= '0;
         strobe_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         strobe_q <= strobe_d;
      end
   end

   assign strobe = strobe_q;

endmodule

// File: rtl/ce_pll_multi.sv
// NUM_CH fractional clock-enable strobes in the refclk domain with lock and reconfig.
// Optional macro CE_PLL_MULTI_PHASE_ALIGN_EN adds sync_in to realign all channel phases.
module ce_pll_multi
   import ce_pll_pkg::*;
#(
   parameter int unsigned NUM_CH      = 5,
   parameter int unsigned ACC_W       = 16,
   parameter int unsigned LOCK_CYCLES = 1024,
   parameter logic [NUM_CH*ACC_W-1:0] DEF_NUM = STD_DEF_NUM,
   parameter logic [NUM_CH*ACC_W-1:0] DEF_DEN = STD_DEF_DEN,
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1
) (
   input  logic              refclk,
   input  logic              rst_n,
`ifdef CE_PLL_MULTI_PHASE_ALIGN_EN
   input  logic              sync_in,
`endif
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]  cfg_num,
   input  logic [ACC_W-1:0]  cfg_den,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] ce_out,
   output logic              locked
);

   lock_state_e       state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              locked_q;
   logic              ready_q;
   logic              err_q;

   logic [ACC_W-1:0]  num_q [NUM_CH];
   logic [ACC_W-1:0]  den_q [NUM_CH];
   logic [NUM_CH-1:0] wr_hit;
   logic [NUM_CH-1:0] strobe;

   logic accept;
   logic cfg_ok;
   logic wr;

   assign accept = cfg_valid & ready_q;
   assign cfg_ok = cfg_is_valid(32'(cfg_num), 32'(cfg_den), 32'(cfg_ch), NUM_CH);
   assign wr     = accept & cfg_ok;

   always_comb begin
      wr_hit = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         wr_hit[i] = wr && (cfg_ch == CH_W'(i));
      end
   end

   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state_q  <= RELOCK;
         cnt_q    <= '0;
         locked_q <= 1'b0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q <= accept & ~cfg_ok;
         case (state_q)
            RELOCK: begin
               if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                  state_q  <= LOCKED;
                  cnt_q    <= '0;
                  locked_q <= 1'b1;
                  ready_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            LOCKED: begin
               if (wr) begin
                  state_q  <= RELOCK;
                  cnt_q    <= '0;
                  locked_q <= 1'b0;
                  ready_q  <= 1'b0;
               end
            end
            default: begin
               state_q  <= RELOCK;
               cnt_q    <= '0;
               locked_q <= 1'b0;
               ready_q  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            num_q[i] <= DEF_NUM[i*ACC_W +: ACC_W];
            den_q[i] <= DEF_DEN[i*ACC_W +: ACC_W];
         end
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (wr_hit[i]) begin
               num_q[i] <= cfg_num;
               den_q[i] <= cfg_den;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic clr;
`ifdef CE_PLL_MULTI_PHASE_ALIGN_EN
      assign clr = wr_hit[g] | sync_in;
`else
      assign clr = wr_hit[g];
`endif

      ce_frac_acc #(.ACC_W(ACC_W)) u_acc (
         .clk    (refclk),
         .rst_n  (rst_n),
         .clr    (clr),
         .num    (num_q[g]),
         .den    (den_q[g]),
         .strobe (strobe[g])
      );

      // Reset rates must satisfy 0 < den and num <= den or the accumulator can overflow
      if ((DEF_DEN[g*ACC_W +: ACC_W] == '0) ||
          (DEF_NUM[g*ACC_W +: ACC_W] > DEF_DEN[g*ACC_W +: ACC_W])) begin : g_bad_default
         $error("ce_pll_multi: channel %0d default num/den invalid", g);
      end
   end

   assign ce_out    = strobe & {NUM_CH{locked_q}};
   assign locked    = locked_q;
   assign cfg_ready = ready_q;
   assign cfg_err   = err_q;

endmodule

// File: tb/tb_ce_pll_multi.sv
// Randomized self-checking bench for ce_pll_multi against a rate/lock reference model.
// Model: strobe at step n iff floor(n*num/den) advances; lock after LOCK_CYCLES steps.
module tb_ce_pll_multi;

   localparam int NCH = 5;
   localparam int AW  = 16;
   localparam int LC  = 8;

   logic           refclk = 1'b0;
   logic           rst_n = 1'b0;
   logic           cfg_valid = 1'b0;
   logic           cfg_ready;
   logic [2:0]     cfg_ch = '0;
   logic [AW-1:0]  cfg_num = '0;
   logic [AW-1:0]  cfg_den = '0;
   logic           cfg_err;
   logic [NCH-1:0] ce_out;
   logic           locked;

   always #5 refclk = ~refclk;

   ce_pll_multi #(
      .NUM_CH      (NCH),
      .ACC_W       (AW),
      .LOCK_CYCLES (LC)
   ) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_num   (cfg_num),
      .cfg_den   (cfg_den),
      .cfg_err   (cfg_err),
      .ce_out    (ce_out),
      .locked    (locked)
   );

   int unsigned def_num [NCH] = '{9, 6, 3, 12, 24};
   int unsigned def_den [NCH] = '{25, 25, 25, 25, 25};

   longint num_m  [NCH];
   longint den_m  [NCH];
   longint step_m [NCH];
   bit     stb_m  [NCH];
   int     run_m = 0;
   bit     locked_m = 1'b0;
   bit     err_m = 1'b0;
   int     cnt [NCH];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
      end
   endtask

   function automatic bit fires(longint n, longint num, longint den);
      return ((n * num) / den) != (((n - 1) * num) / den);
   endfunction

   // Advance the model with the currently driven inputs, clock once, compare.
   task automatic tick();
      bit accept, ok;
      logic [NCH-1:0] exp_ce;
      accept = cfg_valid && locked_m;
      ok = (cfg_den != 0) && (cfg_num != 0) && (cfg_num <= cfg_den) && (cfg_ch < NCH);
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            num_m[i] = def_num[i];
            den_m[i] = def_den[i];
            step_m[i] = 0;
            stb_m[i] = 1'b0;
         end
         run_m = 0;
         err_m = 1'b0;
      end else begin
         err_m = accept && !ok;
         if (accept && ok) run_m = 0;
         else if (run_m < LC) run_m++;
         for (int i = 0; i < NCH; i++) begin
            if (accept && ok && (int'(cfg_ch) == i)) begin
               num_m[i] = cfg_num;
               den_m[i] = cfg_den;
               step_m[i] = 0;
               stb_m[i] = 1'b0;
            end else begin
               step_m[i]++;
               stb_m[i] = fires(step_m[i], num_m[i], den_m[i]);
            end
         end
      end
      locked_m = (run_m >= LC);
      for (int i = 0; i < NCH; i++) exp_ce[i] = stb_m[i] & locked_m;

      @(posedge refclk);
      #1;
      chk("locked", 32'(locked), 32'(locked_m));
      chk("cfg_ready", 32'(cfg_ready), 32'(locked_m));
      chk("cfg_err", 32'(cfg_err), 32'(err_m));
      chk("ce_out", 32'(ce_out), 32'(exp_ce));
      for (int i = 0; i < NCH; i++) if (ce_out[i]) cnt[i]++;
   endtask

   task automatic clear_counts();
      for (int i = 0; i < NCH; i++) cnt[i] = 0;
   endtask

   task automatic reset_and_lock(input int n_rst);
      rst_n = 1'b0;
      cfg_valid = 1'b0;
      repeat (n_rst) tick();
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd0);
      chk("rst_ce", 32'(ce_out), 32'd0);
      chk("rst_err", 32'(cfg_err), 32'd0);
      rst_n = 1'b1;
      for (int k = 1; k <= LC + 2; k++) begin
         tick();
         chk("lock_time", 32'(locked), (k >= LC) ? 32'd1 : 32'd0);
      end
   endtask

   task automatic write_cfg(input int ch, input int num, input int den);
      cfg_ch = 3'(ch);
      cfg_num = AW'(num);
      cfg_den = AW'(den);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_lock();
      int budget;
      budget = LC + 4;
      while (!locked && budget > 0) begin
         tick();
         budget--;
      end
      chk("relock_timeout", 32'(locked), 32'd1);
   endtask

   task automatic check_rates(input int r0, input int r1, input int r2, input int r3, input int r4);
      int exp_r [NCH];
      exp_r = '{r0, r1, r2, r3, r4};
      clear_counts();
      repeat (250) tick();
      for (int i = 0; i < NCH; i++) chk($sformatf("rate_ch%0d", i), 32'(cnt[i]), 32'(exp_r[i]));
   endtask

   initial begin
      // Lock timing and default rates
      reset_and_lock(3);
      check_rates(90, 60, 30, 120, 240);

      // Reprogram ch2 to 1/2
      write_cfg(2, 1, 2);
      chk("wr_ready_drop", 32'(cfg_ready), 32'd0);
      chk("wr_locked_drop", 32'(locked), 32'd0);
      repeat (LC - 2) tick();
      chk("wr_still_relock", 32'(locked), 32'd0);
      wait_lock();
      check_rates(90, 60, 125, 120, 240);

      // Invalid writes: num>den, den=0, channel out of range
      write_cfg(1, 5, 4);
      chk("inv_err_numden", 32'(cfg_err), 32'd1);
      tick();
      write_cfg(1, 3, 0);
      chk("inv_err_den0", 32'(cfg_err), 32'd1);
      tick();
      write_cfg(7, 1, 2);
      chk("inv_err_ch", 32'(cfg_err), 32'd1);
      tick();
      chk("inv_locked", 32'(locked), 32'd1);
      check_rates(90, 60, 125, 120, 240);

      // Reset halfway through a relock
      write_cfg(0, 1, 3);
      repeat (LC / 2) tick();
      reset_and_lock(1);
      check_rates(90, 60, 30, 120, 240);

      // Randomized writes (valid and invalid) with rare resets
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 399) != 0);
         cfg_valid = ($urandom_range(0, 11) == 0);
         cfg_ch = 3'($urandom_range(0, 7));
         cfg_den = AW'($urandom_range(0, 40));
         cfg_num = AW'($urandom_range(0, int'(cfg_den) + 3));
         tick();
      end
      rst_n = 1'b1;
      cfg_valid = 1'b0;
      repeat (LC + 2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
